// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_WAIT  = 2'b10
  } fetch_state_e;

  // Word-align a byte address by clearing the two low bits.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return addr & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/fetch_sequencer_tick_gen.sv
// Enable-gated divider producing a one-cycle tick every DIV_MAX+1 enabled cycles.
module fetch_sequencer_tick_gen #(
  parameter int unsigned DIV_W   = 24,
  parameter int unsigned DIV_MAX = 9_999_999
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_c_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Counter is held at zero whenever the divider is not enabled.
  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != DIV_W'(DIV_MAX))) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_c_o = en_i && (cnt_q == DIV_W'(DIV_MAX));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the synchronous imem and
// presents one captured instruction per fetch with run/step/halt control.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DIV_W   = 24,
  parameter int unsigned DIV_MAX = 9_999_999,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        mode_i,
  input  logic              step_btn_i,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              imem_en_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  fetch_state_e      state_q, state_d;
  logic              imem_en_q, imem_en_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              step_prev_q;
  logic              pend_q, pend_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;

  mode_e mode;
  logic  tick_c;
  logic  advance_c;

  assign mode = mode_e'(mode_i);

  fetch_sequencer_tick_gen #(
    .DIV_W   (DIV_W),
    .DIV_MAX (DIV_MAX)
  ) u_tick_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (mode == MODE_RUN),
    .tick_c_o (tick_c)
  );

  // Advance source depends on mode; reserved code behaves as HALT.
  always_comb begin
    advance_c = 1'b0;
    case (mode)
      MODE_RUN:  advance_c = tick_c;
      MODE_STEP: advance_c = step_btn_i && !step_prev_q;
      default:   advance_c = 1'b0;
    endcase
  end

  // Next-state, PC/redirect bookkeeping and capture on fetch completion.
  always_comb begin
    state_d   = state_q;
    imem_en_d = 1'b0;
    pc_d      = pc_q;
    inst_d    = inst_q;
    valid_d   = 1'b0;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    tgt_d     = tgt_q;

    // Newest redirect wins, including one arriving on the completion edge.
    if (redirect_i) begin
      pend_d = 1'b1;
      tgt_d  = align_pc(redirect_pc_i);
    end

    case (state_q)
      ST_IDLE: begin
        if (advance_c) begin
          state_d   = ST_FETCH;
          imem_en_d = 1'b1;
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_IDLE;
        inst_d  = imem_rdata_i;
        valid_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        pc_d   = pend_d ? tgt_d : pc_q + PC_W'(PC_STEP);
        pend_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      imem_en_q   <= 1'b0;
      pc_q        <= '0;
      inst_q      <= '0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      step_prev_q <= 1'b0;
      pend_q      <= 1'b0;
      tgt_q       <= '0;
    end else begin
      state_q     <= state_d;
      imem_en_q   <= imem_en_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      step_prev_q <= step_btn_i;
      pend_q      <= pend_d;
      tgt_q       <= tgt_d;
    end
  end

  assign imem_en_o    = imem_en_q;
  assign imem_addr_o  = pc_q[ADDR_W+1:2];
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised bench for fetch_sequencer against a cycle-count reference model.
module tb_fetch_sequencer;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DIV_W   = 4;
  localparam int unsigned DIV_MAX = 3;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        mode;
  logic              step_btn;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [31:0]       pc;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic [CNT_W-1:0]  fetch_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int          m_div;
  bit          m_prev;
  int          m_left;   // cycles until the fetch in flight completes (0 = none)
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  bit          m_valid;
  int          m_cnt;
  bit          m_pend;
  logic [31:0] m_tgt;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DIV_W   (DIV_W),
    .DIV_MAX (DIV_MAX),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mode_i        (mode),
    .step_btn_i    (step_btn),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_en_o     (imem_en),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .pc_o          (pc),
    .inst_o        (inst),
    .inst_valid_o  (inst_valid),
    .fetch_cnt_o   (fetch_cnt)
  );

  // Synchronous imem: word i holds 0x1000_0000 + i
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_div = 0; m_prev = 0; m_left = 0; m_pc = '0; m_inst = '0;
    m_valid = 0; m_cnt = 0; m_pend = 0; m_tgt = '0;
  endfunction

  function automatic void model_edge();
    bit tick = 0;
    bit adv  = 0;
    if (mode == 2'b01) begin
      tick  = (m_div == int'(DIV_MAX));
      m_div = tick ? 0 : m_div + 1;
    end else begin
      m_div = 0;
    end
    if (mode == 2'b01) adv = tick;
    else if (mode == 2'b10) adv = step_btn && !m_prev;
    m_prev  = step_btn;
    m_valid = 0;
    if (m_left == 1) begin
      m_inst  = 32'h1000_0000 + ((m_pc >> 2) % DEPTH);
      m_valid = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
      if (redirect)    m_pc = redirect_pc & 32'hFFFF_FFFC;
      else if (m_pend) m_pc = m_tgt;
      else             m_pc = m_pc + 32'd4;
      m_pend = 0;
      m_left = 0;
    end else begin
      if (redirect) begin
        m_pend = 1;
        m_tgt  = redirect_pc & 32'hFFFF_FFFC;
      end
      if (m_left == 2) m_left = 1;
      else if (adv)    m_left = 2;
    end
  endfunction

  task automatic compare_all();
    chk("pc",         pc, m_pc);
    chk("imem_en",    32'(imem_en), 32'(m_left == 2));
    chk("imem_addr",  32'(imem_addr), (m_pc >> 2) % DEPTH);
    chk("inst",       inst, m_inst);
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("fetch_cnt",  32'(fetch_cnt), 32'(m_cnt));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge();
    #1 compare_all();
  endtask

  // Asynchronous reset asserted mid-cycle, held across one edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 compare_all();
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_state(input int left, input string tag);
    for (int i = 0; i < 40 && m_left != left; i++) cyc();
    chk(tag, 32'(m_left == left && (left != 2 || imem_en)), 32'd1);
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0023;
      1:       return 32'hFFFF_FFFC;
      2:       return 32'h0000_003C;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; mode = 2'b00; step_btn = 1'b0; redirect = 1'b0; redirect_pc = '0;
    model_reset();
    #2 compare_all();
    @(posedge clk);
    #1 compare_all();
    #2 rst_n = 1'b1;

    // Halted after reset: nothing should happen
    for (int i = 0; i < 6; i++) cyc();

    // RUN long enough for the PC to wrap the 16-word imem
    mode = 2'b01;
    for (int i = 0; i < 80; i++) cyc();

    // Reset while a fetch is in its wait cycle
    wait_state(1, "wait_mid_fetch");
    do_reset();
    for (int i = 0; i < 6; i++) cyc();

    // Redirect during FETCH to an unaligned target
    wait_state(2, "wait_fetch_a");
    redirect = 1'b1; redirect_pc = 32'h0000_0023;
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) cyc();

    // Two redirects before completion: the later one wins
    wait_state(0, "wait_idle_b");
    redirect = 1'b1; redirect_pc = 32'h0000_0104;
    cyc();
    redirect_pc = 32'h0000_0030;
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 10; i++) cyc();

    // PC wrap at the top of the 32-bit space
    wait_state(2, "wait_fetch_c");
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 12; i++) cyc();

    // HALT mid-fetch, then reserved mode, with a redirect held pending
    wait_state(2, "wait_fetch_d");
    mode = 2'b00;
    for (int i = 0; i < 10; i++) cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_0010;
    cyc();
    redirect = 1'b0;
    mode = 2'b11;
    for (int i = 0; i < 10; i++) cyc();

    // STEP with random button levels of varying hold length
    mode = 2'b10;
    for (int i = 0; i < 60; i++) begin
      step_btn = ~step_btn;
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) cyc();
    end

    // Fully random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 4))
          0, 1:    mode = 2'b01;
          2:       mode = 2'b10;
          3:       mode = 2'b00;
          default: mode = 2'b11;
        endcase
      end
      if ($urandom_range(0, 2) == 0) step_btn = ~step_btn;
      redirect = ($urandom_range(0, 11) == 0);
      if (redirect) redirect_pc = pick_pc();
      cyc();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
